// File: rtl/network_requester.sv
`default_nettype none
// ============================================================================
// Module   : network_requester
// Brief    : Core-side injection interface. Sends one load/store packet at a
//            time and returns the reply, with read timeout, retry and failure.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module network_requester #(
  parameter int NET_W          = `NETWORK_ADDRESS_WIDTH,
  parameter int BANK_W         = `CACHE_BANK_ADDRESS_WIDTH,
  parameter int DATA_W         = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NET_W-1:0]        localRouterAddress,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [NET_W+BANK_W-1:0] reqAddress,
  input  logic [DATA_W-1:0]       reqData,
  output logic                    respValid,
  output logic [DATA_W-1:0]       respData,
  output logic                    respTimeout,
  input  logic                    portEnable,
  output logic [NET_W+BANK_W-1:0] destinationAddressOut,
  output logic [NET_W-1:0]        requesterAddressOut,
  output logic                    readOut,
  output logic                    writeOut,
  output logic [DATA_W-1:0]       dataOut,
  input  logic [NET_W+BANK_W-1:0] destinationAddressIn,
  input  logic [NET_W-1:0]        requesterAddressIn,
  input  logic                    readIn,
  input  logic                    writeIn,
  input  logic [DATA_W-1:0]       dataIn
);

  localparam int c_addrW  = NET_W + BANK_W;
  localparam int c_countW = $clog2(TIMEOUT_CYCLES);
  localparam int c_retryW = $clog2(MAX_RETRIES + 2);
  localparam logic [c_countW-1:0] c_lastCount  = c_countW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_retryW-1:0] c_maxRetries = c_retryW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_write;
  logic [c_addrW-1:0]   r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [c_countW-1:0]  r_count;
  logic [c_retryW-1:0]  r_retries;

  logic                 w_match;
  logic                 w_capture;
  logic                 w_retryInc;
  logic                 w_sendNext;
  logic                 w_pktWrite;
  logic [c_addrW-1:0]   w_pktAddr;
  logic [DATA_W-1:0]    w_pktData;
  logic                 w_respValid;
  logic [DATA_W-1:0]    w_respData;
  logic                 w_respTimeout;
  logic                 w_unusedBank;

  // Reply bank bits carry no meaning for the requester.
  assign w_unusedBank = ^destinationAddressIn[BANK_W-1:0];

  assign reqReady  = (r_state == IDLE) && !reset;
  assign w_capture = (r_state == IDLE) && reqValid;
  assign w_match   = (r_state == WAIT) && writeIn && !readIn &&
                     (destinationAddressIn[c_addrW-1:BANK_W] == localRouterAddress) &&
                     (requesterAddressIn == r_addr[c_addrW-1:BANK_W]);

  // The packet launched on entry to SEND comes straight from the request
  // when capturing, otherwise from the held copy (retry path).
  assign w_sendNext = (w_nextState == SEND);
  assign w_pktWrite = (r_state == IDLE) ? reqWrite   : r_write;
  assign w_pktAddr  = (r_state == IDLE) ? reqAddress : r_addr;
  assign w_pktData  = (r_state == IDLE) ? reqData    : r_data;

  always_comb begin
    w_nextState   = r_state;
    w_retryInc    = 1'b0;
    w_respValid   = 1'b0;
    w_respData    = '0;
    w_respTimeout = 1'b0;
    case (r_state)
      IDLE: if (reqValid) w_nextState = SEND;
      SEND: begin
        if (portEnable) begin
          w_nextState = r_write ? RESP : WAIT;
          w_respValid = r_write;
        end
      end
      WAIT: begin
        if (w_match) begin
          w_nextState = RESP;
          w_respValid = 1'b1;
          w_respData  = dataIn;
        end else if (r_count == c_lastCount) begin
          if (r_retries < c_maxRetries) begin
            w_nextState = SEND;
            w_retryInc  = 1'b1;
          end else begin
            w_nextState   = RESP;
            w_respValid   = 1'b1;
            w_respTimeout = 1'b1;
          end
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= IDLE;
      r_write               <= 1'b0;
      r_addr                <= '0;
      r_data                <= '0;
      r_count               <= '0;
      r_retries             <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      destinationAddressOut <= '0;
      requesterAddressOut   <= '0;
      dataOut               <= '0;
      respValid             <= 1'b0;
      respData              <= '0;
      respTimeout           <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_capture) begin
        r_write   <= reqWrite;
        r_addr    <= reqAddress;
        r_data    <= reqData;
        r_retries <= '0;
      end else if (w_retryInc) begin
        r_retries <= r_retries + 1'b1;
      end
      r_count <= ((r_state == WAIT) && (w_nextState == WAIT)) ? r_count + 1'b1 : '0;

      readOut               <= w_sendNext && !w_pktWrite;
      writeOut              <= w_sendNext && w_pktWrite;
      destinationAddressOut <= w_sendNext ? w_pktAddr : '0;
      requesterAddressOut   <= w_sendNext ? localRouterAddress : '0;
      dataOut               <= (w_sendNext && w_pktWrite) ? w_pktData : '0;
      respValid             <= w_respValid;
      respData              <= w_respData;
      respTimeout           <= w_respTimeout;
    end
  end

endmodule

`default_nettype wire
